// File: rtl/turn_signal_sequencer.sv
// Tail-light sequencer: sequential left/right fill, hazard flash and brake overlay.
// Step timing comes from an internal prescaler; all outputs are registered.
module turn_signal_sequencer #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 12500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
  input  logic               brake,
  output logic [2*LAMPS-1:0] status,
  output logic [1:0]         mode,
  output logic               tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEFT_SEQ  = 3'd1,
    RIGHT_SEQ = 3'd2,
    HAZ_ON    = 3'd3,
    HAZ_OFF   = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      step, step_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               both, dir_cur, dir_oth;
  logic [LAMPS-1:0]   left_lit, right_lit;
  logic [2*LAMPS-1:0] status_nx;
  logic [1:0]         mode_nx;

  assign both    = left & right;
  assign dir_cur = (state == LEFT_SEQ) ? left  : right;
  assign dir_oth = (state == LEFT_SEQ) ? right : left;

  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      IDLE: begin
        // IDLE reacts on any edge, without waiting for a tick
        if (hazard || both) begin
          state_nx = HAZ_ON;
          step_nx  = '0;
        end else if (left) begin
          state_nx = LEFT_SEQ;
          step_nx  = STEP_ONE;
        end else if (right) begin
          state_nx = RIGHT_SEQ;
          step_nx  = STEP_ONE;
        end
      end
      LEFT_SEQ, RIGHT_SEQ: begin
        if (tick) begin
          if (hazard) begin
            state_nx = HAZ_ON;
            step_nx  = '0;
          end else if (step == '0) begin
            if (dir_cur) begin
              step_nx = STEP_ONE;
            end else if (dir_oth) begin
              state_nx = (state == LEFT_SEQ) ? RIGHT_SEQ : LEFT_SEQ;
              step_nx  = STEP_ONE;
            end else begin
              state_nx = IDLE;
              step_nx  = '0;
            end
          end else if (step == STEP_LAST) begin
            step_nx = '0;
          end else begin
            step_nx = step + STEP_ONE;
          end
        end
      end
      HAZ_ON, HAZ_OFF: begin
        step_nx = '0;
        if (tick) begin
          if (hazard || both) state_nx = (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
          else                state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        step_nx  = '0;
      end
    endcase
  end

  // Counter is pinned at zero in IDLE so the first step after leaving is full length
  always_comb begin
    if (state == IDLE || cnt == CNT_LAST) cnt_nx = '0;
    else                                  cnt_nx = cnt + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < LAMPS; i++) begin
      left_lit[i]  = (state_nx == LEFT_SEQ)  && (int'(step_nx) > i);
      right_lit[i] = (state_nx == RIGHT_SEQ) && (int'(step_nx) >= LAMPS - i);
    end
  end

  always_comb begin
    status_nx = '0;
    mode_nx   = 2'b00;
    case (state_nx)
      HAZ_ON: begin
        status_nx = '1;
        mode_nx   = 2'b11;
      end
      HAZ_OFF: begin
        status_nx = '0;
        mode_nx   = 2'b11;
      end
      default: begin
        // Brake lights every lamp the active turn side does not own
        status_nx = {left_lit  | {LAMPS{brake && (state_nx != LEFT_SEQ)}},
                     right_lit | {LAMPS{brake && (state_nx != RIGHT_SEQ)}}};
        if (state_nx == LEFT_SEQ)       mode_nx = 2'b01;
        else if (state_nx == RIGHT_SEQ) mode_nx = 2'b10;
        else                            mode_nx = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      step   <= '0;
      cnt    <= '0;
      tick   <= 1'b0;
      status <= '0;
      mode   <= 2'b00;
    end else begin
      state  <= state_nx;
      step   <= step_nx;
      cnt    <= cnt_nx;
      tick   <= (cnt_nx == CNT_LAST);
      status <= status_nx;
      mode   <= mode_nx;
    end
  end

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed scenarios followed by randomized switch activity, all checked cycle by
// cycle against a behavioural model of the tail-light rules.
module tb_turn_signal_sequencer;
  localparam int L  = 3;
  localparam int TD = 4;

  logic           clk = 1'b0;
  logic           reset, left, right, hazard, brake;
  logic [2*L-1:0] status;
  logic [1:0]     mode;
  logic           tick;

  int n_cmp = 0;
  int n_bad = 0;

  // model: ms 0 idle, 1 left, 2 right, 3 hazard lit, 4 hazard dark
  int ms, mk, mc;

  turn_signal_sequencer #(.LAMPS(L), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .status(status), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mk = 0; mc = 0;
  endtask

  task automatic model_edge();
    bit tk, both, cur, oth;
    tk   = (ms != 0) && (mc == TD - 1);
    both = left && right;
    if (ms == 0) begin
      mc = 0;
      if (hazard || both) ms = 3;
      else if (left)  begin ms = 1; mk = 1; end
      else if (right) begin ms = 2; mk = 1; end
    end else begin
      mc = tk ? 0 : mc + 1;
      if (tk) begin
        if (ms == 1 || ms == 2) begin
          if (hazard) ms = 3;
          else if (mk == 0) begin
            cur = (ms == 1) ? left : right;
            oth = (ms == 1) ? right : left;
            if (cur)      mk = 1;
            else if (oth) begin ms = 3 - ms; mk = 1; end
            else          ms = 0;
          end else mk = (mk == L) ? 0 : mk + 1;
        end else begin
          ms = (hazard || both) ? 7 - ms : 0;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_status();
    int lh, rh, full;
    full = (1 << L) - 1;
    if (ms == 3) return full * (1 << L) + full;
    if (ms == 4) return 0;
    lh = (ms == 1) ? (1 << mk) - 1 : 0;
    rh = (ms == 2) ? ((1 << mk) - 1) << (L - mk) : 0;
    if (brake && ms != 1) lh = full;
    if (brake && ms != 2) rh = full;
    return lh * (1 << L) + rh;
  endfunction

  function automatic logic [31:0] exp_mode();
    return (ms >= 3) ? 3 : ms;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("status", status, exp_status());
    check("mode",   mode,   exp_mode());
    check("tick",   tick,   (mc == TD - 1) ? 1 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    model_reset();
    #12;
    check("reset_status", status, 0);
    check("reset_mode",   mode,   0);
    check("reset_tick",   tick,   0);

    // left held from reset release, then hazard preempt
    left = 1'b1;
    @(negedge clk); reset = 1'b0;
    cyc();  check("left_s1", status, 6'b001000); check("left_mode", mode, 2'b01);
    run(4); check("left_s2", status, 6'b011000);
    run(4); check("left_s3", status, 6'b111000);
    run(4); check("left_dark", status, 6'b000000);
    run(4); check("left_restart", status, 6'b001000);
    run(4); check("left_s2b", status, 6'b011000);
    hazard = 1'b1;
    run(4); check("haz_on", status, 6'b111111); check("haz_mode", mode, 2'b11);
    run(4); check("haz_off", status, 6'b000000);
    run(4); check("haz_on2", status, 6'b111111);
    hazard = 1'b0; left = 1'b0;
    run(4); check("haz_exit", status, 6'b000000); check("haz_exit_mode", mode, 2'b00);

    // brake overlay
    brake = 1'b1;
    cyc();  check("brake_idle", status, 6'b111111);
    left = 1'b1;
    cyc();  check("brake_l1", status, 6'b001111);
    run(4); check("brake_l2", status, 6'b011111);
    run(4); check("brake_l3", status, 6'b111111);
    run(4); check("brake_l0", status, 6'b000111);
    left = 1'b0; brake = 1'b0;
    run(4); check("brake_exit", mode, 2'b00);

    // right pulsed for one cycle
    right = 1'b1;
    cyc();  check("right_s1", status, 6'b000100);
    right = 1'b0;
    run(4); check("right_s2", status, 6'b000110);
    run(4); check("right_s3", status, 6'b000111);
    run(4); check("right_dark", status, 6'b000000);
    run(4); check("right_idle", mode, 2'b00);

    // direction switch mid-sequence
    left = 1'b1;
    cyc();  run(4); check("sw_l2", status, 6'b011000);
    left = 1'b0; right = 1'b1;
    run(4); check("sw_l3", status, 6'b111000);
    run(4); check("sw_dark", status, 6'b000000);
    run(4); check("sw_r1", status, 6'b000100); check("sw_mode", mode, 2'b10);
    right = 1'b0;
    run(12);

    // async reset between edges
    left = 1'b1;
    run(3);
    #2 reset = 1'b1;
    #1;
    check("areset_status", status, 0);
    check("areset_mode",   mode,   0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    cyc(); check("areset_relaunch", status, 6'b001000);
    left = 1'b0;
    run(16);

    // randomized switch activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) left   = ~left;
      if ($urandom_range(24, 0) == 0) right  = ~right;
      if ($urandom_range(59, 0) == 0) hazard = ~hazard;
      if ($urandom_range(14, 0) == 0) brake  = ~brake;
      if ($urandom_range(499, 0) == 0) begin
        reset = 1'b1;
        #1;
        check("rand_reset_status", status, 0);
        check("rand_reset_mode",   mode,   0);
        model_reset();
        #1 reset = 1'b0;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
